mem_line_responder: RTL
=======================

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 Parameter LATENCY, 8, cycles from request acceptance to mem_ready pulse; legal range 1..15.
REQ-002 Parameter DEPTH, 256, number of 128-bit lines stored; power of two.
REQ-003 Parameter IDX_W, 8, log2(DEPTH); line index = mem_addr[IDX_W-1:0].
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 proc_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mem_read  input  1  line read request from cache, level, held until serviced.
REQ-007 mem_write  input  1  line write request from cache, level, held until serviced.
REQ-008 mem_addr  input  28  line address; bits above IDX_W ignored.
REQ-009 mem_wdata  input  128  write line data.
REQ-010 mem_rdata  output  128  read line data, registered.
REQ-011 mem_ready  output  1  completion pulse, registered, one cycle wide.

Function
REQ-012 States SHALL be IDLE, BUSY, DONE.
REQ-013 IDLE: on an edge with mem_read or mem_write high, SHALL latch op, index and mem_wdata, load counter with LATENCY-1, and go to BUSY.
REQ-014 Both mem_read and mem_write high at acceptance SHALL be treated as a write.
REQ-015 BUSY: counter decrements each edge; at counter 0 the next edge SHALL enter DONE and set mem_ready=1.
REQ-016 With LATENCY=1, mem_ready SHALL rise on the edge after acceptance.
REQ-017 Net latency: acceptance edge k -> mem_ready high during cycle following edge k+LATENCY.
REQ-018 Write completion: the array line SHALL be updated with the latched wdata on the edge that raises mem_ready.
REQ-019 Read completion: mem_rdata SHALL be loaded with the array line on the edge that raises mem_ready.
REQ-020 mem_rdata SHALL hold its value until the next read completion (cache samples it one cycle after mem_ready).
REQ-021 DONE: next edge SHALL clear mem_ready and return to IDLE unconditionally, ignoring requests (request still high from registered cache side is not re-accepted).
REQ-022 A request first seen in IDLE the cycle after DONE SHALL be accepted (write-back followed by allocate read, back-to-back).
REQ-023 Inputs SHALL be ignored in BUSY; deassertion of a request mid-BUSY SHALL not abort the transaction.
REQ-024 Read of a line never written SHALL return the array's power-up/initial content (zero when preloaded by bench).
REQ-025 Index wrap: mem_addr beyond DEPTH SHALL alias modulo DEPTH.

Reset
REQ-026 proc_reset_n low SHALL immediately force state IDLE, counter 0, mem_ready 0, mem_rdata 0.
REQ-027 Reset mid-BUSY SHALL abort; a pending write SHALL not be committed.
REQ-028 Array contents SHALL not be reset.
REQ-029 First acceptance SHALL occur no earlier than the first edge after proc_reset_n rises.

Structure
REQ-030 Shared package SHALL hold state encoding, LINE_W=128, ADDR_W=28, default LATENCY and DEPTH.
REQ-031 Storage SHALL be a sub-module line_mem_array: DEPTH x 128, one synchronous write port, one synchronous read port.
REQ-032 Control FSM, counter and output registers SHALL remain in mem_line_responder.

Verification
REQ-033 LATENCY=8, read addr 0x05 preloaded 0xA..A -> mem_ready single pulse 8 cycles after acceptance, mem_rdata=0xA..A, held 2+ cycles after.
REQ-034 Write addr 0x12 data 0x1234..., then read 0x12 -> read returns 0x1234...; mem_ready pulses exactly twice.
REQ-035 Cache-style write-back then allocate (write 0x03 held through ready+1, then read 0x07) -> exactly one write and one read serviced, no duplicate ready.
REQ-036 mem_read and mem_write both high, addr 0x20 -> treated as write, line 0x20 updated, mem_rdata unchanged.
REQ-037 proc_reset_n pulsed low mid-BUSY of write to 0x30 -> mem_ready stays 0, line 0x30 unchanged, next request serviced normally.
REQ-038 LATENCY=1 and addr 0x1_0000_05 -> ready one cycle after acceptance, aliased to line 0x05.

Source files
------------

// File: rtl/mem_line_responder_pkg.sv
// mem_line_responder_pkg: shared widths, defaults and FSM encoding for the line responder.
package mem_line_responder_pkg;
    localparam int LINE_W      = 128;
    localparam int ADDR_W      = 28;
    localparam int DEF_LATENCY = 8;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_IDX_W   = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/mem_line_responder_array.sv
// line_mem_array: DEPTH x LINE_W storage, one synchronous write port and one registered read port.
import mem_line_responder_pkg::*;
module line_mem_array #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [LINE_W-1:0] rdata
);
    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: fixed-latency line memory model answering cache line reads/writes with a one-cycle ready pulse.
import mem_line_responder_pkg::*;
module mem_line_responder #(
    parameter int LATENCY = DEF_LATENCY,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready
);
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic [LINE_W-1:0] arr_rdata;
    logic [IDX_W-1:0]  arr_raddr;
    logic              arr_we;
    logic              unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[ADDR_W-1:IDX_W];
    // Array read is registered, so address it with the incoming index while idle; the line is ready by completion.
    assign arr_raddr = (state_q == IDLE) ? mem_addr[IDX_W-1:0] : idx_q;
    assign arr_we    = (state_q == BUSY) && (cnt_q == 4'd0) && wr_q;
    line_mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
        .clk  (clk),
        .we   (arr_we),
        .waddr(idx_q),
        .wdata(wdata_q),
        .raddr(arr_raddr),
        .rdata(arr_rdata)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: if (mem_read || mem_write) begin
                state_d = BUSY;
                cnt_d   = 4'(LATENCY - 1);
                wr_d    = mem_write;
                idx_d   = mem_addr[IDX_W-1:0];
                wdata_d = mem_wdata;
            end
            BUSY: if (cnt_q == 4'd0) begin
                state_d = DONE;
                ready_d = 1'b1;
                rdata_d = wr_q ? rdata_q : arr_rdata;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end
    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
endmodule
